// File: rtl/intc_pkg.sv
// Shared types, constants and helpers for the prioritised interrupt controller.
package intc_pkg;

  // Default parameter values for the controller.
  localparam int DEF_NUM_GRP   = 3;
  localparam int DEF_NUM_CH    = 9;
  localparam bit DEF_EDGE_MODE = 1'b1;
  localparam bit DEF_MASK_RST  = 1'b0;

  // Service sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESENT  = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_e;

  // Index width that never collapses to zero bits for a single group/channel.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Find-first-set over the group-major request vector.
// The lowest flat index wins: lowest group first, then lowest channel in it.
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int NUM_GRP = DEF_NUM_GRP,
  parameter int NUM_CH  = DEF_NUM_CH
) (
  input  logic [NUM_GRP*NUM_CH-1:0]          vec_i,
  output logic                               any_o,
  output logic [clog2_min1(NUM_GRP)-1:0]     grp_o,
  output logic [clog2_min1(NUM_CH)-1:0]      ch_o
);

  localparam int GW = clog2_min1(NUM_GRP);
  localparam int CW = clog2_min1(NUM_CH);

  // Scan from the highest index down so the last hit is the lowest index.
  always_comb begin
    any_o = 1'b0;
    grp_o = '0;
    ch_o  = '0;
    for (int g = NUM_GRP - 1; g >= 0; g--) begin
      for (int c = NUM_CH - 1; c >= 0; c--) begin
        if (vec_i[g*NUM_CH + c]) begin
          any_o = 1'b1;
          grp_o = GW'(g);
          ch_o  = CW'(c);
        end
      end
    end
  end

endmodule

// File: rtl/intc_prio_seq.sv
// Sequential prioritised interrupt controller: pending capture (edge or
// level), per-request masking, per-channel enable and a valid/ready service
// handshake with a one-cycle cooldown between services.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no winner presented; latch the arbitration winner if any
// PRESENT   | winner held stable on irq_grp_o/irq_ch_o until accepted
// COOLDOWN  | one dead cycle after an accept, then back to IDLE
module intc_prio_seq
  import intc_pkg::*;
#(
  parameter int NUM_GRP   = DEF_NUM_GRP,
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter bit EDGE_MODE = DEF_EDGE_MODE,
  parameter bit MASK_RST  = DEF_MASK_RST
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_GRP*NUM_CH-1:0]          req_i,
  input  logic [NUM_CH-1:0]                  ch_en_i,
  input  logic                               mask_we_i,
  input  logic [NUM_GRP*NUM_CH-1:0]          mask_wdata_i,
  output logic                               irq_valid_o,
  input  logic                               irq_ready_i,
  output logic [clog2_min1(NUM_GRP)-1:0]     irq_grp_o,
  output logic [clog2_min1(NUM_CH)-1:0]      irq_ch_o,
  output logic [NUM_GRP*NUM_CH-1:0]          pend_o
);

  localparam int NR = NUM_GRP * NUM_CH;
  localparam int GW = clog2_min1(NUM_GRP);
  localparam int CW = clog2_min1(NUM_CH);

  localparam logic [1:0] S_IDLE     = ST_IDLE;
  localparam logic [1:0] S_PRESENT  = ST_PRESENT;
  localparam logic [1:0] S_COOLDOWN = ST_COOLDOWN;

  logic [1:0]    state;
  logic [NR-1:0] req_q;
  logic [NR-1:0] pend;
  logic [NR-1:0] pend_nxt;
  logic [NR-1:0] mask;
  logic [NR-1:0] in_svc;
  logic [NR-1:0] in_svc_nxt;
  logic [NR-1:0] elig;
  logic [NR-1:0] clr_vec;
  logic          accept;
  logic          win_any;
  logic [GW-1:0] win_grp;
  logic [CW-1:0] win_ch;

  assign irq_valid_o = (state == S_PRESENT);
  assign accept      = irq_valid_o & irq_ready_i;
  assign pend_o      = pend;
  assign elig        = pend & ~mask & {NUM_GRP{ch_en_i}};

  intc_prio_enc #(
    .NUM_GRP (NUM_GRP),
    .NUM_CH  (NUM_CH)
  ) u_enc (
    .vec_i (elig),
    .any_o (win_any),
    .grp_o (win_grp),
    .ch_o  (win_ch)
  );

  // One-hot of the presented winner, only during the accepting cycle.
  always_comb begin
    clr_vec = '0;
    for (int g = 0; g < NUM_GRP; g++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        clr_vec[g*NUM_CH + c] = accept && (irq_grp_o == GW'(g)) && (irq_ch_o == CW'(c));
      end
    end
  end

  // Next pending / in-service state. In edge mode a new rising edge in the
  // accept cycle outranks the clear. In level mode a serviced bit stays
  // blocked until its request has been seen low; a request already low at
  // accept time needs no block.
  always_comb begin
    pend_nxt   = '0;
    in_svc_nxt = '0;
    if (EDGE_MODE) begin
      pend_nxt   = (pend & ~clr_vec) | (req_i & ~req_q);
      in_svc_nxt = '0;
    end else begin
      pend_nxt   = req_i & ~in_svc & ~clr_vec;
      in_svc_nxt = (in_svc | clr_vec) & req_i;
    end
  end

  // Request history, pending latches, in-service flags and mask register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= '0;
      pend   <= '0;
      in_svc <= '0;
      mask   <= {NR{MASK_RST}};
    end else begin
      req_q  <= req_i;
      pend   <= pend_nxt;
      in_svc <= in_svc_nxt;
      if (mask_we_i) begin
        mask <= mask_wdata_i;
      end
    end
  end

  // Service sequencer; the winner is latched once and held until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      irq_grp_o <= '0;
      irq_ch_o  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_any) begin
            irq_grp_o <= win_grp;
            irq_ch_o  <= win_ch;
            state     <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (irq_ready_i) begin
            state <= S_COOLDOWN;
          end
        end
        S_COOLDOWN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intc_prio_seq.sv
// Bench for intc_prio_seq: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural model. One edge-mode
// and one level-mode instance share all inputs.
module tb_intc_prio_seq;

  localparam int NR = 27;

  logic          clk;
  logic          rst_n;
  logic [NR-1:0] req;
  logic [8:0]    ch_en;
  logic          mask_we;
  logic [NR-1:0] mask_wdata;
  logic          ready;

  logic          e_valid, l_valid;
  logic [1:0]    e_grp, l_grp;
  logic [3:0]    e_ch, l_ch;
  logic [NR-1:0] e_pend, l_pend;

  int n_cmp  = 0;
  int n_fail = 0;

  intc_prio_seq #(.NUM_GRP(3), .NUM_CH(9), .EDGE_MODE(1'b1), .MASK_RST(1'b0)) u_edge (
    .clk(clk), .rst_n(rst_n), .req_i(req), .ch_en_i(ch_en), .mask_we_i(mask_we),
    .mask_wdata_i(mask_wdata), .irq_valid_o(e_valid), .irq_ready_i(ready),
    .irq_grp_o(e_grp), .irq_ch_o(e_ch), .pend_o(e_pend)
  );

  intc_prio_seq #(.NUM_GRP(3), .NUM_CH(9), .EDGE_MODE(1'b0), .MASK_RST(1'b0)) u_level (
    .clk(clk), .rst_n(rst_n), .req_i(req), .ch_en_i(ch_en), .mask_we_i(mask_we),
    .mask_wdata_i(mask_wdata), .irq_valid_o(l_valid), .irq_ready_i(ready),
    .irq_grp_o(l_grp), .irq_ch_o(l_ch), .pend_o(l_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [NR-1:0] req;
    logic          rdy;
    logic          mwe;
    logic [NR-1:0] mwd;
    logic          valid;
    logic          chk_idx;
    logic [1:0]    grp;
    logic [3:0]    ch;
    logic [NR-1:0] pend;
  } vec_t;

  typedef struct {
    logic [NR-1:0] pend;
    logic [NR-1:0] mask;
    logic [NR-1:0] req_q;
    logic [NR-1:0] insvc;
    int            phase;   // 0 idle, 1 presenting, 2 cooldown
    int            wg;
    int            wc;
  } model_t;

  vec_t   tbl [24];
  model_t em, lm;

  function automatic logic [NR-1:0] b(input int i);
    logic [NR-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic vec_t mk(input logic [NR-1:0] r, input logic rd, input logic we,
                              input logic [NR-1:0] wd, input logic v, input logic ci,
                              input int g, input int c, input logic [NR-1:0] p);
    vec_t t;
    t.req = r; t.rdy = rd; t.mwe = we; t.mwd = wd; t.valid = v; t.chk_idx = ci;
    t.grp = 2'(g); t.ch = 4'(c); t.pend = p;
    return t;
  endfunction

  function automatic model_t model_reset();
    model_t m;
    m.pend = '0; m.mask = '0; m.req_q = '0; m.insvc = '0;
    m.phase = 0; m.wg = 0; m.wc = 0;
    return m;
  endfunction

  // Behavioural next state from the controller's rules.
  function automatic model_t model_step(input model_t m, input bit edge_m,
                                        input logic [NR-1:0] r, input logic [8:0] en,
                                        input logic we, input logic [NR-1:0] wd,
                                        input logic rd);
    model_t n;
    bit     acc;
    int     widx;
    int     found;
    n     = m;
    acc   = (m.phase == 1) && rd;
    widx  = m.wg * 9 + m.wc;
    for (int i = 0; i < NR; i++) begin
      if (edge_m) begin
        n.pend[i] = (r[i] && !m.req_q[i]) || (m.pend[i] && !(acc && i == widx));
      end else if (acc && i == widx) begin
        n.pend[i]  = 1'b0;
        n.insvc[i] = r[i];
      end else begin
        n.pend[i]  = r[i] && !m.insvc[i];
        n.insvc[i] = m.insvc[i] && r[i];
      end
    end
    if (m.phase == 0) begin
      found = -1;
      for (int i = 0; i < NR; i++) begin
        if (found < 0 && m.pend[i] && !m.mask[i] && en[i % 9]) found = i;
      end
      if (found >= 0) begin
        n.phase = 1;
        n.wg    = found / 9;
        n.wc    = found % 9;
      end
    end else if (m.phase == 1) begin
      if (rd) n.phase = 2;
    end else begin
      n.phase = 0;
    end
    if (we) n.mask = wd;
    n.req_q = r;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [NR-1:0] r, input logic rd);
    @(negedge clk);
    req   = r;
    ready = rd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0; ready = 1'b0; mask_we = 1'b0; mask_wdata = '0; ch_en = '1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    em = model_reset();
    lm = model_reset();
  endtask

  initial begin
    logic [NR-1:0] r;
    logic [8:0]    en;
    logic          we, rd;
    logic [NR-1:0] wd;

    tbl[0]  = mk(b(13),        0, 0, '0,   0, 0, 0, 0, b(13));
    tbl[1]  = mk('0,           0, 0, '0,   1, 1, 1, 4, b(13));
    tbl[2]  = mk('0,           1, 0, '0,   0, 0, 0, 0, '0);
    tbl[3]  = mk('0,           0, 0, '0,   0, 0, 0, 0, '0);
    tbl[4]  = mk(b(20) | b(3), 0, 0, '0,   0, 0, 0, 0, b(20) | b(3));
    tbl[5]  = mk('0,           0, 0, '0,   1, 1, 0, 3, b(20) | b(3));
    tbl[6]  = mk('0,           1, 0, '0,   0, 0, 0, 0, b(20));
    tbl[7]  = mk('0,           0, 0, '0,   0, 0, 0, 0, b(20));
    tbl[8]  = mk('0,           0, 0, '0,   1, 1, 2, 2, b(20));
    tbl[9]  = mk(b(0),         0, 0, '0,   1, 1, 2, 2, b(20) | b(0));
    tbl[10] = mk('0,           0, 0, '0,   1, 1, 2, 2, b(20) | b(0));
    tbl[11] = mk('0,           1, 0, '0,   0, 0, 0, 0, b(0));
    tbl[12] = mk('0,           0, 0, '0,   0, 0, 0, 0, b(0));
    tbl[13] = mk('0,           0, 0, '0,   1, 1, 0, 0, b(0));
    tbl[14] = mk('0,           1, 0, '0,   0, 0, 0, 0, '0);
    tbl[15] = mk('0,           0, 0, '0,   0, 0, 0, 0, '0);
    tbl[16] = mk('0,           0, 1, b(5), 0, 0, 0, 0, '0);
    tbl[17] = mk(b(5),         0, 0, '0,   0, 0, 0, 0, b(5));
    tbl[18] = mk('0,           0, 0, '0,   0, 0, 0, 0, b(5));
    tbl[19] = mk('0,           0, 0, '0,   0, 0, 0, 0, b(5));
    tbl[20] = mk('0,           0, 1, '0,   0, 0, 0, 0, b(5));
    tbl[21] = mk('0,           0, 0, '0,   1, 1, 0, 5, b(5));
    tbl[22] = mk('0,           1, 0, '0,   0, 0, 0, 0, '0);
    tbl[23] = mk('0,           0, 0, '0,   0, 0, 0, 0, '0);

    rst_n = 1'b0;
    req = '0; ready = 1'b0; mask_we = 1'b0; mask_wdata = '0; ch_en = '1;
    #1;
    check("rst_valid", 32'(e_valid), 32'd0);
    check("rst_grp", 32'(e_grp), 32'd0);
    check("rst_ch", 32'(e_ch), 32'd0);
    check("rst_pend", 32'(e_pend), 32'd0);
    do_reset();

    // Directed table on the edge-mode instance.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      req = tbl[i].req; ready = tbl[i].rdy; mask_we = tbl[i].mwe; mask_wdata = tbl[i].mwd;
      tick();
      check($sformatf("tbl%0d_valid", i), 32'(e_valid), 32'(tbl[i].valid));
      check($sformatf("tbl%0d_pend", i), 32'(e_pend), 32'(tbl[i].pend));
      if (tbl[i].chk_idx) begin
        check($sformatf("tbl%0d_grp", i), 32'(e_grp), 32'(tbl[i].grp));
        check($sformatf("tbl%0d_ch", i), 32'(e_ch), 32'(tbl[i].ch));
      end
    end
    @(negedge clk);
    mask_we = 1'b0;

    // New rising edge in the accept cycle keeps the bit pending.
    set_in(b(13), 0); tick();
    set_in('0, 0);    tick();
    check("sw_valid", 32'(e_valid), 32'd1);
    set_in(b(13), 1); tick();
    check("sw_cool_valid", 32'(e_valid), 32'd0);
    check("sw_pend_kept", 32'(e_pend), 32'(b(13)));
    set_in('0, 0);    tick();
    set_in('0, 0);    tick();
    check("sw_repr_valid", 32'(e_valid), 32'd1);
    check("sw_repr_ch", 32'(e_ch), 32'd4);
    set_in('0, 1);    tick();
    check("sw_clear", 32'(e_pend), 32'd0);
    set_in('0, 0);    tick();

    // Level mode: held request is not re-presented until it drops and rises.
    do_reset();
    set_in(b(8), 0); tick();
    check("lv_pend", 32'(l_pend), 32'(b(8)));
    set_in(b(8), 0); tick();
    check("lv_valid", 32'(l_valid), 32'd1);
    check("lv_ch", 32'(l_ch), 32'd8);
    set_in(b(8), 1); tick();
    check("lv_acc_valid", 32'(l_valid), 32'd0);
    check("lv_acc_pend", 32'(l_pend), 32'd0);
    for (int k = 0; k < 5; k++) begin
      set_in(b(8), 0); tick();
      check($sformatf("lv_block%0d_valid", k), 32'(l_valid), 32'd0);
      check($sformatf("lv_block%0d_pend", k), 32'(l_pend), 32'd0);
    end
    set_in('0, 0);   tick();
    check("lv_low_pend", 32'(l_pend), 32'd0);
    set_in(b(8), 0); tick();
    check("lv_rise_pend", 32'(l_pend), 32'(b(8)));
    set_in(b(8), 0); tick();
    check("lv_repr_valid", 32'(l_valid), 32'd1);
    check("lv_repr_ch", 32'(l_ch), 32'd8);
    set_in('0, 1); tick();
    set_in('0, 0); tick();

    // Randomized run against the behavioural model, both capture modes.
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      check("rnd_e_valid", 32'(e_valid), 32'(em.phase == 1));
      check("rnd_e_grp", 32'(e_grp), 32'(em.wg));
      check("rnd_e_ch", 32'(e_ch), 32'(em.wc));
      check("rnd_e_pend", 32'(e_pend), 32'(em.pend));
      check("rnd_l_valid", 32'(l_valid), 32'(lm.phase == 1));
      check("rnd_l_grp", 32'(l_grp), 32'(lm.wg));
      check("rnd_l_ch", 32'(l_ch), 32'(lm.wc));
      check("rnd_l_pend", 32'(l_pend), 32'(lm.pend));
      r  = NR'($urandom & $urandom & $urandom);
      en = ($urandom_range(0, 7) == 0) ? 9'($urandom) : 9'h1ff;
      we = ($urandom_range(0, 15) == 0);
      wd = NR'($urandom & $urandom);
      rd = 1'($urandom);
      req = r; ch_en = en; mask_we = we; mask_wdata = wd; ready = rd;
      em = model_step(em, 1'b1, r, en, we, wd, rd);
      lm = model_step(lm, 1'b0, r, en, we, wd, rd);
    end

    // Reset while presenting: valid drops at once, mask returns to unmasked.
    do_reset();
    @(negedge clk);
    mask_we = 1'b1; mask_wdata = b(7);
    @(negedge clk);
    mask_we = 1'b0;
    set_in(b(2), 0); tick();
    set_in('0, 0);   tick();
    check("rp_valid_before", 32'(e_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rp_valid_async", 32'(e_valid), 32'd0);
    check("rp_pend_async", 32'(e_pend), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(b(7), 0); tick();
    check("rp_pend7", 32'(e_pend), 32'(b(7)));
    set_in('0, 0);   tick();
    check("rp_mask_cleared_valid", 32'(e_valid), 32'd1);
    check("rp_mask_cleared_ch", 32'(e_ch), 32'd7);
    set_in('0, 1); tick();
    set_in('0, 0); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
